// File: rtl/iob_axil_arbiter_pkg.sv
// Shared definitions for the IOb-to-AXI4-Lite round-robin arbiter:
// FSM state encoding, fixed AXI constants and width helpers.
package iob_axil_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RRESP
  } state_t;

  localparam logic [2:0] AXIL_PROT     = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Width of the watchdog counter able to hold the value timeout_cycles.
  function automatic int tmo_cnt_w(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request
// searching upward from ptr+1 and wrapping around to ptr itself.
module iob_rr_arbiter
  import iob_axil_arbiter_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic found;

  // Two passes: requesters above the pointer first, then wrap to those at or below it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[j] && (j > int'(ptr))) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        found    = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[j] && (j <= int'(ptr))) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_axil_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite manager port between N_REQ IOb
// subordinate ports, one outstanding transaction at a time.
// Optional watchdog: define IOB_AXIL_ARBITER_TIMEOUT_EN to abort transactions
// that stay outside IDLE for TIMEOUT_CYCLES cycles.
module iob_axil_arbiter
  import iob_axil_arbiter_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int AXIL_ADDR_W    = 21,
  parameter int AXIL_DATA_W    = 32,
  parameter int ADDR_W         = AXIL_ADDR_W,
  parameter int DATA_W         = AXIL_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          iob_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]   iob_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   iob_wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0] iob_wstrb_i,
  output logic [N_REQ-1:0]          iob_ready_o,
  output logic [N_REQ-1:0]          iob_rvalid_o,
  output logic [DATA_W-1:0]         iob_rdata_o,
  output logic                      axil_awvalid_o,
  input  logic                      axil_awready_i,
  output logic [AXIL_ADDR_W-1:0]    axil_awaddr_o,
  output logic [2:0]                axil_awprot_o,
  output logic                      axil_wvalid_o,
  input  logic                      axil_wready_i,
  output logic [AXIL_DATA_W-1:0]    axil_wdata_o,
  output logic [AXIL_DATA_W/8-1:0]  axil_wstrb_o,
  input  logic                      axil_bvalid_i,
  output logic                      axil_bready_o,
  input  logic [1:0]                axil_bresp_i,
  output logic                      axil_arvalid_o,
  input  logic                      axil_arready_i,
  output logic [AXIL_ADDR_W-1:0]    axil_araddr_o,
  output logic [2:0]                axil_arprot_o,
  input  logic                      axil_rvalid_i,
  output logic                      axil_rready_o,
  input  logic [AXIL_DATA_W-1:0]    axil_rdata_i,
  input  logic [1:0]                axil_rresp_i,
  output logic                      axil_err_o
);

  localparam int IDX_W       = idx_w(N_REQ);
  localparam int STRB_W      = DATA_W / 8;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, grant_idx;
  logic [N_REQ-1:0]   grant, owner_q, rvalid_q;
  logic [ADDR_W-1:0]  sel_addr, addr_q;
  logic [DATA_W-1:0]  sel_wdata, wdata_q, rdata_q;
  logic [STRB_W-1:0]  sel_wstrb, wstrb_q;
  logic               aw_done_q, w_done_q, err_q;
  logic               accept, tmo;
  logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;

  iob_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req  (iob_valid_i),
    .ptr  (ptr_q),
    .grant(grant),
    .idx  (grant_idx)
  );

  // Pick the granted requester's address, data and strobes for latching.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_addr  = iob_addr_i[k*ADDR_W +: ADDR_W];
        sel_wdata = iob_wdata_i[k*DATA_W +: DATA_W];
        sel_wstrb = iob_wstrb_i[k*STRB_W +: STRB_W];
      end
    end
  end

`ifdef IOB_AXIL_ARBITER_TIMEOUT_EN
  localparam int TMO_W = tmo_cnt_w(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt_q;

  // Watchdog: counts cycles spent outside IDLE; idle holds it at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == ST_IDLE) tmo_cnt_q <= '0;
    else                             tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end

  assign tmo = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign tmo            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs, all decoded from registered state.
  always_comb begin
    state_d        = state_q;
    iob_ready_o    = '0;
    axil_awvalid_o = 1'b0;
    axil_wvalid_o  = 1'b0;
    axil_bready_o  = 1'b0;
    axil_arvalid_o = 1'b0;
    axil_rready_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|iob_valid_i) begin
          iob_ready_o = grant;
          state_d     = (|sel_wstrb) ? ST_WADDR : ST_RADDR;
        end
      end
      ST_WADDR: begin
        axil_awvalid_o = ~aw_done_q;
        axil_wvalid_o  = ~w_done_q;
        if ((aw_done_q || axil_awready_i) && (w_done_q || axil_wready_i)) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        axil_bready_o = 1'b1;
        if (axil_bvalid_i) state_d = ST_IDLE;
      end
      ST_RADDR: begin
        axil_arvalid_o = 1'b1;
        if (axil_arready_i) state_d = ST_RRESP;
      end
      ST_RRESP: begin
        axil_rready_o = 1'b1;
        if (axil_rvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo) begin
      state_d        = ST_IDLE;
      axil_awvalid_o = 1'b0;
      axil_wvalid_o  = 1'b0;
      axil_bready_o  = 1'b0;
      axil_arvalid_o = 1'b0;
      axil_rready_o  = 1'b0;
    end
  end

  assign accept = (state_q == ST_IDLE) && (|iob_valid_i);
  assign aw_hs  = axil_awvalid_o & axil_awready_i;
  assign w_hs   = axil_wvalid_o & axil_wready_i;
  assign b_hs   = axil_bvalid_i & axil_bready_o;
  assign ar_hs  = axil_arvalid_o & axil_arready_i;
  assign r_hs   = axil_rvalid_i & axil_rready_o;

  // Transaction context, AW/W completion flags and one-cycle response pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= IDX_W'(N_REQ - 1);
      owner_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      rvalid_q <= '0;
      err_q    <= 1'b0;
      if (accept) begin
        ptr_q     <= grant_idx;
        owner_q   <= grant;
        addr_q    <= sel_addr;
        wdata_q   <= sel_wdata;
        wstrb_q   <= sel_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (b_hs)  err_q     <= (axil_bresp_i != AXI_RESP_OKAY);
      if (r_hs) begin
        rdata_q  <= DATA_W'(axil_rdata_i);
        rvalid_q <= owner_q;
        err_q    <= (axil_rresp_i != AXI_RESP_OKAY);
      end
      if (tmo) begin
        err_q <= 1'b1;
        if (state_q == ST_RADDR || state_q == ST_RRESP) begin
          rdata_q  <= '1;
          rvalid_q <= owner_q;
        end
      end
    end
  end

  assign iob_rvalid_o  = rvalid_q;
  assign iob_rdata_o   = rdata_q;
  assign axil_err_o    = err_q;
  assign axil_awaddr_o = AXIL_ADDR_W'(addr_q);
  assign axil_araddr_o = AXIL_ADDR_W'(addr_q);
  assign axil_awprot_o = AXIL_PROT;
  assign axil_arprot_o = AXIL_PROT;
  assign axil_wdata_o  = AXIL_DATA_W'(wdata_q);
  assign axil_wstrb_o  = AXIL_STRB_W'(wstrb_q);

endmodule

// File: tb/tb_iob_axil_arbiter.sv
// Directed self-checking bench for iob_axil_arbiter with a small AXI4-Lite
// subordinate model (configurable AW delay, response codes, stalls).
module tb_iob_axil_arbiter;

  localparam int N  = 2;
  localparam int AW = 21;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [N-1:0]      iob_valid_i;
  logic [N*AW-1:0]   iob_addr_i;
  logic [N*DW-1:0]   iob_wdata_i;
  logic [N*DW/8-1:0] iob_wstrb_i;
  logic [N-1:0]      iob_ready_o, iob_rvalid_o;
  logic [DW-1:0]     iob_rdata_o;
  logic              axil_awvalid_o, axil_awready_i;
  logic [AW-1:0]     axil_awaddr_o, axil_araddr_o;
  logic [2:0]        axil_awprot_o, axil_arprot_o;
  logic              axil_wvalid_o, axil_wready_i;
  logic [DW-1:0]     axil_wdata_o, axil_rdata_i;
  logic [DW/8-1:0]   axil_wstrb_o;
  logic              axil_bvalid_i, axil_bready_o;
  logic [1:0]        axil_bresp_i, axil_rresp_i;
  logic              axil_arvalid_o, axil_arready_i;
  logic              axil_rvalid_i, axil_rready_o;
  logic              axil_err_o;

  // Subordinate model knobs (changed only at negedge, away from model updates).
  int          aw_delay   = 0;
  bit          b_hold     = 1'b0;
  bit          r_hang     = 1'b0;
  logic [31:0] rdata_knob = '0;
  logic [1:0]  rresp_knob = 2'b00;
  logic [1:0]  bresp_knob = 2'b00;
  int          aw_beats   = 0;
  int          w_beats    = 0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iob_axil_arbiter #(
    .N_REQ(N), .AXIL_ADDR_W(AW), .AXIL_DATA_W(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .iob_valid_i(iob_valid_i), .iob_addr_i(iob_addr_i),
    .iob_wdata_i(iob_wdata_i), .iob_wstrb_i(iob_wstrb_i),
    .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o), .iob_rdata_o(iob_rdata_o),
    .axil_awvalid_o(axil_awvalid_o), .axil_awready_i(axil_awready_i),
    .axil_awaddr_o(axil_awaddr_o), .axil_awprot_o(axil_awprot_o),
    .axil_wvalid_o(axil_wvalid_o), .axil_wready_i(axil_wready_i),
    .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o),
    .axil_bvalid_i(axil_bvalid_i), .axil_bready_o(axil_bready_o), .axil_bresp_i(axil_bresp_i),
    .axil_arvalid_o(axil_arvalid_o), .axil_arready_i(axil_arready_i),
    .axil_araddr_o(axil_araddr_o), .axil_arprot_o(axil_arprot_o),
    .axil_rvalid_i(axil_rvalid_i), .axil_rready_o(axil_rready_o),
    .axil_rdata_i(axil_rdata_i), .axil_rresp_i(axil_rresp_i),
    .axil_err_o(axil_err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Subordinate: samples handshakes at negedge, updates its outputs just after posedge.
  initial begin : sub_model
    bit s_aw_hs, s_w_hs, s_ar_hs, s_b_hs, s_r_hs, s_aw_seen, s_rst;
    bit aw_got, w_got;
    int aw_cnt;
    aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0;
    axil_awready_i = 1'b1; axil_wready_i = 1'b1; axil_arready_i = 1'b1;
    axil_bvalid_i = 1'b0; axil_bresp_i = 2'b00;
    axil_rvalid_i = 1'b0; axil_rdata_i = '0; axil_rresp_i = 2'b00;
    forever begin
      @(negedge clk);
      s_aw_hs   = axil_awvalid_o & axil_awready_i;
      s_w_hs    = axil_wvalid_o & axil_wready_i;
      s_ar_hs   = axil_arvalid_o & axil_arready_i;
      s_b_hs    = axil_bvalid_i & axil_bready_o;
      s_r_hs    = axil_rvalid_i & axil_rready_o;
      s_aw_seen = axil_awvalid_o;
      s_rst     = rst_i;
      if (s_aw_hs) aw_beats++;
      if (s_w_hs)  w_beats++;
      @(posedge clk);
      #1;
      if (s_rst) begin
        aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0;
        axil_bvalid_i = 1'b0; axil_rvalid_i = 1'b0;
      end else begin
        if (s_aw_hs) begin aw_got = 1'b1; aw_cnt = 0; end
        else if (s_aw_seen) aw_cnt++;
        if (s_w_hs) w_got = 1'b1;
        if (s_b_hs) axil_bvalid_i = 1'b0;
        if (s_r_hs) axil_rvalid_i = 1'b0;
        if (aw_got && w_got && !b_hold) begin
          axil_bvalid_i = 1'b1; axil_bresp_i = bresp_knob;
          aw_got = 1'b0; w_got = 1'b0;
        end
        if (s_ar_hs && !r_hang) begin
          axil_rvalid_i = 1'b1; axil_rdata_i = rdata_knob; axil_rresp_i = rresp_knob;
        end
      end
      axil_awready_i = (aw_cnt >= aw_delay);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int got, rv, aw0, w0;
    rst_i = 1'b1; iob_valid_i = '0; iob_addr_i = '0; iob_wdata_i = '0; iob_wstrb_i = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    smp();
    check("rst_ready", iob_ready_o, 0);
    check("rst_rvalid", iob_rvalid_o, 0);
    check("rst_rdata", iob_rdata_o, 0);
    check("rst_err", axil_err_o, 0);
    check("rst_valids", {axil_awvalid_o, axil_wvalid_o, axil_arvalid_o}, 0);
    check("rst_readies", {axil_bready_o, axil_rready_o}, 0);
    check("prot", axil_arprot_o, 2);

    // Single zero-wait read from requester 0.
    rdata_knob = 32'hDEADBEEF;
    tick(); iob_valid_i = 2'b01; iob_addr_i[0 +: AW] = 21'h10; iob_wstrb_i = '0;
    smp(); check("rd_ready_c0", iob_ready_o, 2'b01);
    tick(); iob_valid_i = '0;
    smp(); check("rd_arvalid_c1", axil_arvalid_o, 1); check("rd_araddr_c1", axil_araddr_o, 21'h10);
    check("rd_ready_c1", iob_ready_o, 0);
    tick(); smp(); check("rd_rready_c2", axil_rready_o, 1); check("rd_arvalid_c2", axil_arvalid_o, 0);
    tick(); smp(); check("rd_rvalid_c3", iob_rvalid_o, 2'b01); check("rd_rdata_c3", iob_rdata_o, 32'hDEADBEEF);
    check("rd_err_c3", axil_err_o, 0);
    tick(); smp(); check("rd_rvalid_c4", iob_rvalid_o, 0);

    // Write where W completes three cycles before AW.
    aw_delay = 3; aw0 = aw_beats; w0 = w_beats;
    tick(); iob_valid_i = 2'b01; iob_addr_i[0 +: AW] = 21'h20;
    iob_wdata_i[0 +: DW] = 32'h12345678; iob_wstrb_i[0 +: 4] = 4'hF;
    smp(); check("wr_ready_c0", iob_ready_o, 2'b01);
    tick(); iob_valid_i = '0; iob_wstrb_i = '0;
    smp(); check("wr_aw_w_c1", {axil_awvalid_o, axil_wvalid_o}, 2'b11);
    check("wr_wdata", axil_wdata_o, 32'h12345678); check("wr_wstrb", axil_wstrb_o, 4'hF);
    check("wr_awaddr", axil_awaddr_o, 21'h20); check("wr_bready_c1", axil_bready_o, 0);
    tick(); smp(); check("wr_aw_w_c2", {axil_awvalid_o, axil_wvalid_o}, 2'b10);
    tick(); smp(); check("wr_aw_w_c3", {axil_awvalid_o, axil_wvalid_o}, 2'b10);
    tick(); smp(); check("wr_aw_w_c4", {axil_awvalid_o, axil_wvalid_o}, 2'b10);
    check("wr_bready_c4", axil_bready_o, 0);
    tick(); smp(); check("wr_bready_c5", axil_bready_o, 1); check("wr_awvalid_c5", axil_awvalid_o, 0);
    tick(); smp(); check("wr_bready_c6", axil_bready_o, 0); check("wr_rvalid_c6", iob_rvalid_o, 0);
    check("wr_err_c6", axil_err_o, 0);
    check("wr_aw_beats", aw_beats - aw0, 1); check("wr_w_beats", w_beats - w0, 1);
    aw_delay = 0;

    // Reset, then both requesters held valid: grants and responses alternate 0,1,...
    tick(); rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    rdata_knob = 32'h11110000;
    tick(); iob_valid_i = 2'b11; iob_addr_i[0 +: AW] = 21'h100; iob_addr_i[AW +: AW] = 21'h200;
    got = 0; rv = 0;
    for (int c = 0; c < 80 && (got < 6 || rv < 6); c++) begin
      smp();
      if (|iob_ready_o) begin
        check($sformatf("arb_grant%0d", got), iob_ready_o, (got % 2) ? 2'b10 : 2'b01);
        got++;
      end
      if (|iob_rvalid_o) begin
        check($sformatf("arb_rvalid%0d", rv), iob_rvalid_o, (rv % 2) ? 2'b10 : 2'b01);
        rv++;
      end
      tick();
      if (got >= 6) iob_valid_i = '0;
    end
    check("arb_grants", got, 6); check("arb_resps", rv, 6);

    // Read with SLVERR from requester 1 alone.
    rresp_knob = 2'b10; rdata_knob = 32'hCAFEF00D;
    tick(); iob_valid_i = 2'b10; iob_addr_i[AW +: AW] = 21'h300;
    smp(); check("er_ready_c0", iob_ready_o, 2'b10);
    tick(); iob_valid_i = '0;
    smp(); check("er_err_c1", axil_err_o, 0);
    tick(); smp(); check("er_err_c2", axil_err_o, 0);
    tick(); smp(); check("er_rvalid_c3", iob_rvalid_o, 2'b10); check("er_rdata_c3", iob_rdata_o, 32'hCAFEF00D);
    check("er_err_c3", axil_err_o, 1);
    tick(); smp(); check("er_err_c4", axil_err_o, 0); check("er_rvalid_c4", iob_rvalid_o, 0);
    rresp_knob = 2'b00;

    // Reset while waiting for B, then a normal read.
    b_hold = 1'b1;
    tick(); iob_valid_i = 2'b01; iob_addr_i[0 +: AW] = 21'h40;
    iob_wdata_i[0 +: DW] = 32'hA5A5A5A5; iob_wstrb_i[0 +: 4] = 4'h3;
    smp(); check("rs_ready_c0", iob_ready_o, 2'b01);
    tick(); iob_valid_i = '0; iob_wstrb_i = '0;
    smp(); check("rs_aw_w_c1", {axil_awvalid_o, axil_wvalid_o}, 2'b11);
    tick(); smp(); check("rs_bready_c2", axil_bready_o, 1);
    tick(); rst_i = 1'b1; smp();
    tick(); rst_i = 1'b0;
    smp(); check("rs_valids", {axil_awvalid_o, axil_wvalid_o, axil_arvalid_o}, 0);
    check("rs_readies", {axil_bready_o, axil_rready_o}, 0);
    check("rs_iob", {iob_ready_o, iob_rvalid_o}, 0);
    b_hold = 1'b0; rdata_knob = 32'h0BADC0DE;
    tick(); iob_valid_i = 2'b01; iob_addr_i[0 +: AW] = 21'h44;
    smp(); check("rs_rd_ready", iob_ready_o, 2'b01);
    tick(); iob_valid_i = '0;
    smp(); check("rs_rd_araddr", axil_araddr_o, 21'h44);
    tick(); smp();
    tick(); smp(); check("rs_rd_rvalid", iob_rvalid_o, 2'b01); check("rs_rd_rdata", iob_rdata_o, 32'h0BADC0DE);

`ifdef IOB_AXIL_ARBITER_TIMEOUT_EN
    // Read that never returns R: watchdog aborts with all-ones data.
    r_hang = 1'b1;
    tick(); iob_valid_i = 2'b01; iob_addr_i[0 +: AW] = 21'h50;
    smp(); check("to_ready_c0", iob_ready_o, 2'b01);
    tick(); iob_valid_i = '0; smp();
    repeat (7) begin tick(); smp(); end
    check("to_rvalid_c8", iob_rvalid_o, 0); check("to_err_c8", axil_err_o, 0);
    tick(); smp();
    check("to_rvalid_c9", iob_rvalid_o, 2'b01); check("to_rdata_c9", iob_rdata_o, 32'hFFFFFFFF);
    check("to_err_c9", axil_err_o, 1); check("to_rready_c9", axil_rready_o, 0);
    r_hang = 1'b0;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/iob_axil_arbiter.md
Name: iob_axil_arbiter

Overview:
- Shares one AXI4-Lite manager port between N_REQ IOb subordinate ports, using round-robin arbitration.
- Sequences each transaction fully: AW/W handshakes are tracked independently, B/R is awaited, and the read response is routed back to the owning requester.
- One outstanding transaction at a time.
- Sits between CPU/DMA IOb buses and a single AXI-Lite peripheral or interconnect.

Parameters:
- N_REQ, 2, number of IOb requesters (≥1).
- AXIL_ADDR_W, 21, AXI-Lite address width.
- AXIL_DATA_W, 32, AXI-Lite data width (multiple of 8).
- ADDR_W, AXIL_ADDR_W, IOb address width.
- DATA_W, AXIL_DATA_W, IOb data width.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- iob_valid_i  in  N_REQ  per-requester request.
- iob_addr_i  in  N_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W].
- iob_wdata_i  in  N_REQ*DATA_W  packed write data.
- iob_wstrb_i  in  N_REQ*DATA_W/8  packed strobes; nonzero = write, zero = read.
- iob_ready_o  out  N_REQ  request accepted (one-hot or zero).
- iob_rvalid_o  out  N_REQ  read data valid (one-hot or zero).
- iob_rdata_o  out  DATA_W  read data, shared by all requesters, qualified by iob_rvalid_o.
- axil_aw{valid_o,ready_i,addr_o,prot_o}, axil_w{valid_o,ready_i,data_o,strb_o}, axil_b{valid_i,ready_o,resp_i}, axil_ar{valid_o,ready_i,addr_o,prot_o}, axil_r{valid_i,ready_o,data_i,resp_i}: standard AXI4-Lite manager; prot fixed 3'd2.
- axil_err_o  out  1  one-cycle pulse: non-OKAY bresp/rresp, or timeout.

Behaviour:
- Reset: state IDLE, round-robin pointer = N_REQ-1 (requester 0 wins first). All valid/ready/rvalid outputs and axil_err_o = 0; rdata = 0.
- FSM states: IDLE, WADDR, WRESP, RADDR, RRESP.
- IDLE:
  - If any iob_valid_i is high, grant the first requester searching upward from pointer+1 (wrapping).
  - iob_ready_o[g] = 1 combinationally in that same cycle.
  - Latch addr/wdata/wstrb and g; set pointer = g.
  - Next state: WADDR if |wstrb, else RADDR.
  - iob_ready_o is 0 in all other states.
- WADDR:
  - awvalid = ~aw_done; wvalid = ~w_done. Each done flag is set on its own handshake; AW and W may complete in the same cycle or in either order.
  - Go to WRESP in the cycle both are complete.
  - Outputs are registered: no valid drops before its ready.
- WRESP: bready = 1. On bvalid, go to IDLE; pulse axil_err_o if bresp ≠ 0. Writes produce no iob_rvalid.
- RADDR: arvalid = 1 until arready, then RRESP.
- RRESP:
  - rready = 1.
  - On rvalid: register rdata into iob_rdata_o and pulse iob_rvalid_o[g] for exactly one cycle (the next cycle); go to IDLE.
  - Pulse axil_err_o if rresp ≠ 0.
- Minimum latency with zero-wait subordinate:
  - Read: accept c0, AR c1, R c2, iob_rvalid c3.
  - Write: accept c0, AW+W c1, B c2.
  - A new request may be accepted in the cycle IDLE is re-entered (c3).
- Requesters may drop or change iob_valid_i after acceptance with no effect on the transaction in flight. Non-granted requesters wait with ready = 0.
- B/R arriving in any state other than WRESP/RRESP is ignored (ready = 0).
- Reset mid-transaction: return to IDLE immediately and drop all valids. System reset is required to reset the AXI subordinate too.
- N_REQ = 1: arbitration degenerates; behaviour is otherwise identical.

Optional Feature:
- IOB_AXIL_ARBITER_TIMEOUT_EN:
  - Adds a counter, cleared on leaving IDLE and counting in every non-IDLE state.
  - On reaching TIMEOUT_CYCLES: drop all axil valids, go to IDLE, pulse axil_err_o.
  - If the transaction was a read, also pulse iob_rvalid_o[g] with rdata = all-ones.
- Without the macro: no counter; the block waits indefinitely.

Decomposition:
- Package iob_axil_arbiter_pkg holds:
  - FSM state encoding.
  - AXIL_PROT = 3'd2.
  - AXI_RESP_OKAY = 2'b00.
  - Timeout counter width, computed as $clog2(TIMEOUT_CYCLES+1).
- Sub-module iob_rr_arbiter (combinational, N_REQ param):
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.

Test Plan:
- Single read, req0 addr 0x10, zero-wait subordinate returns 0xDEADBEEF → iob_ready_o=01 at c0, arvalid c1, iob_rvalid_o=01 with rdata 0xDEADBEEF at c3.
- Write with W accepted 3 cycles before AW (awready delayed) → awvalid held until accepted, wvalid drops after its handshake, exactly one W beat, bready only in WRESP.
- req0 and req1 held continuously valid, 6 transactions → grants alternate 0,1,0,1,0,1; first grant to 0 after reset.
- Read with rresp=2'b10 → axil_err_o pulses once, iob_rvalid_o still pulses with returned data.
- rst_i asserted in WRESP → next cycle state IDLE, all valids 0; subsequent read completes normally.
- With IOB_AXIL_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, a read that never gets rvalid → axil_err_o pulses and iob_rvalid_o pulses with rdata = 0xFFFFFFFF, 8 cycles after leaving IDLE.
